// File: rtl/lane_ser_pkg.sv
// lane_ser_pkg: shared encodings, frame lengths and FSM states for the multi-lane serializer.
package lane_ser_pkg;

    localparam logic [1:0] GS_SHORT = 2'b00;
    localparam logic [1:0] GS_LONG  = 2'b01;
    localparam logic [1:0] GS_MID   = 2'b10;
    localparam logic [1:0] GS_ALT   = 2'b11;

    localparam int LEN_SHORT = 8;
    localparam int LEN_MID   = 66;
    localparam int LEN_LONG  = 132;

    typedef enum logic {IDLE, SHIFT} ser_state_t;

    function automatic int unsigned frame_len(input logic [1:0] gs);
        return (gs == GS_LONG) ? LEN_LONG : (gs == GS_MID) ? LEN_MID : LEN_SHORT;
    endfunction

endpackage

// File: rtl/lane_shift_unit.sv
// lane_shift_unit: one lane's shift register and registered serial bit, LSB first.
module lane_shift_unit #(
    parameter int DATA_W = 132
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [DATA_W-1:0] word,
    output logic              ser
);

    logic [DATA_W-1:0] sr;

    // Bit 0 leaves directly on load, so the register keeps the word pre-shifted by one.
    always_ff @(posedge clk) begin
        if (load)
            sr <= word >> 1;
        else if (advance)
            sr <= sr >> 1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ser <= 1'b0;
        else
            ser <= load ? word[0] : advance ? sr[0] : 1'b0;
    end

endmodule

// File: rtl/multi_lane_serializer.sv
// multi_lane_serializer: double-buffered parallel-to-serial converter driving NUM_LANES
// bit-aligned lanes with selectable frame length and scrambler sideband strobes.
module multi_lane_serializer
    import lane_ser_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int DATA_W    = 132
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [1:0]                  gen_speed,
    input  logic [NUM_LANES*DATA_W-1:0] tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [NUM_LANES-1:0]        lane_tx_out,
    output logic                        enable_scr,
    output logic                        scr_rst,
    output logic                        underrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    ser_state_t                  state, state_nxt;
    logic [CNT_W-1:0]            cnt, cnt_nxt;
    logic [CNT_W-1:0]            lq, lq_nxt;
    logic                        hold_full, hold_full_nxt;
    logic [NUM_LANES*DATA_W-1:0] hold;
    logic                        accept, at_end, load, advance, ending;

    assign tx_ready = rst & enable & ~hold_full;
    assign accept   = tx_valid & tx_ready;

    // A frame ending with a word waiting reloads on the same edge, so frames abut.
    always_comb begin
        at_end        = (state == SHIFT) && (cnt == lq);
        load          = enable && hold_full && ((state == IDLE) || at_end);
        advance       = enable && (state == SHIFT) && !at_end;
        ending        = enable && at_end && !hold_full;
        state_nxt     = !enable ? IDLE : load ? SHIFT : ending ? IDLE : state;
        cnt_nxt       = (!enable || ending) ? '0 : load ? CNT_W'(1) : advance ? cnt + CNT_W'(1) : cnt;
        lq_nxt        = load ? CNT_W'(frame_len(gen_speed)) : lq;
        hold_full_nxt = !enable ? 1'b0 : accept ? 1'b1 : load ? 1'b0 : hold_full;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lq         <= CNT_W'(LEN_SHORT);
            hold_full  <= 1'b0;
            enable_scr <= 1'b0;
            scr_rst    <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            lq         <= lq_nxt;
            hold_full  <= hold_full_nxt;
            enable_scr <= load | advance;
            scr_rst    <= load;
            underrun   <= ending;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            hold <= tx_data;
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_shift_unit #(.DATA_W(DATA_W)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .load    (load),
            .advance (advance),
            .word    (hold[i*DATA_W +: DATA_W]),
            .ser     (lane_tx_out[i])
        );
    end

endmodule
